sp_sram_param: RTL and testbench
================================

# sp_sram_param

Parametrised single-port synchronous SRAM for FIR coefficient and sample storage, replacing the fixed 10x16 array. Width, depth and read latency are set by parameters. The block adds a sequential clear engine that runs after reset or on request, a read-valid strobe, and an out-of-range address error flag. It sits between the coefficient-load controller and the MAC datapath, and keeps the existing active-low chip-select and write-enable access protocol.

## Interface
- DATA_W, 16, word width in bits
- DEPTH, 10, number of words; legal addresses are 0..DEPTH-1
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= DEPTH
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2 (2 adds an output register stage)
- INIT_VAL, 0, DATA_W-bit value written by the clear engine
- iClk12M  in  1  system clock; all logic is on the rising edge
- iRst  in  1  reset, synchronous and active-high
- iCsnRam  in  1  chip select, active low
- iWrnRam  in  1  0 = write, 1 = read; qualified by iCsnRam=0
- iAddrRam  in  ADDR_W  access address
- iWtDtRam  in  DATA_W  write data
- iClrReq  in  1  single-cycle request to re-clear the whole array
- oRdDtRam  out  DATA_W  read data
- oRdValid  out  1  one-cycle strobe: oRdDtRam carries the result of a read
- oAddrErr  out  1  one-cycle strobe: an access used an address >= DEPTH
- oBusy  out  1  clear engine active; all accesses are ignored

## Operation
- States:
  - CLEAR: a counter rClrAddr walks 0..DEPTH-1 and writes INIT_VAL to one word per cycle.
  - IDLE: normal access.
- Reset, every cycle iRst=1:
  - state = CLEAR, rClrAddr = 0, oBusy = 1.
  - oRdDtRam = 0, oRdValid = 0, oAddrErr = 0.
  - The RD_LAT pipeline is flushed.
  - Array contents are not guaranteed until the clear completes.
- CLEAR:
  - Each cycle writes mem[rClrAddr] = INIT_VAL and increments rClrAddr.
  - In the cycle rClrAddr = DEPTH-1 the block moves to IDLE.
  - iCsnRam, iWrnRam and iClrReq are ignored: no write, no oRdValid, no oAddrErr.
- IDLE, when iCsnRam=0:
  - Write (iWrnRam=0) with address < DEPTH: mem[addr] = iWtDtRam at the clock edge.
  - Read (iWrnRam=1) with address < DEPTH: mem[addr] is returned on oRdDtRam with oRdValid=1.
  - Read with address >= DEPTH: oRdDtRam = 0, oRdValid = 1, oAddrErr = 1.
  - Write with address >= DEPTH: the write is dropped and oAddrErr = 1. oRdValid stays 0 and oRdDtRam holds.
- IDLE, when iCsnRam=1: no access is performed.
- oRdDtRam holds its last value whenever oRdValid=0.
- iClrReq=1 in IDLE:
  - An access presented in the same cycle still completes normally.
  - The state becomes CLEAR on the next cycle, with rClrAddr = 0.
- Reads already in the RD_LAT=2 pipeline when a clear starts still complete and deliver the pre-clear data.
- Single port: one access per cycle. A write followed by a read of the same address on the next cycle returns the new data.

## Timing
- Clear duration:
  - Let edge E be the first edge at which iRst is sampled 0.
  - Addresses 0..DEPTH-1 are written on edges E..E+DEPTH-1.
  - oBusy falls after edge E+DEPTH-1, so oBusy is high for DEPTH cycles after reset release.
  - The first access is accepted in the cycle after oBusy falls.
- Read latency:
  - A read sampled at edge T drives oRdDtRam and oRdValid after edge T+RD_LAT-1.
  - RD_LAT=1: the outputs are visible in the cycle right after the request.
  - oRdValid lasts exactly one cycle per read.
  - Back-to-back reads give back-to-back valids at full throughput.
- oAddrErr uses the same RD_LAT pipeline for both reads and writes. It is therefore aligned with oRdValid for an erroneous read.
- iClrReq sampled at edge T: oBusy = 1 after edge T, and the clear completes after edge T+DEPTH.
- iRst has priority over everything, including an active clear and any in-flight pipeline stage.

## Test plan
- Reset release, defaults (DEPTH=10) -> oBusy high for exactly 10 cycles. oRdDtRam=0, oRdValid=0 and oAddrErr=0 throughout. Reading addresses 0..9 afterwards returns 0x0000 at each.
- Write 0xA5A5 to address 3, then read address 3 on the next cycle, once with RD_LAT=1 and once with RD_LAT=2 -> oRdDtRam=0xA5A5 with oRdValid after 1 and after 2 cycles respectively.
- Read address 12 -> oRdDtRam=0x0000 with oRdValid=1 and oAddrErr=1 in the same cycle. Write 0xFFFF to address 10 -> oAddrErr pulses and addresses 0..9 are unchanged.
- Fill all 10 words with 0x1000+i, pulse iClrReq together with a read of address 5 -> the read returns 0x1005. oBusy is high for 10 cycles, an access attempted during the clear produces no valid, and all words read 0x0000 afterwards.
- Assert iRst in the 4th cycle of a clear, then release -> the clear restarts from address 0 and oBusy is high for the full 10 cycles.
- Build with DATA_W=32, DEPTH=64, ADDR_W=6 and run back-to-back writes then reads at addresses 0..63 -> data matches, and oRdValid stays high on consecutive cycles during the reads.

Source files
------------

// File: rtl/sp_sram_param.sv
// Parametrised single-port synchronous SRAM with a sequential clear engine,
// read-valid strobe and out-of-range address error flag.
module sp_sram_param #(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 10,
  parameter int                ADDR_W   = 4,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [ADDR_W-1:0] iAddrRam,
  input  logic [DATA_W-1:0] iWtDtRam,
  input  logic              iClrReq,
  output logic [DATA_W-1:0] oRdDtRam,
  output logic              oRdValid,
  output logic              oAddrErr,
  output logic              oBusy
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] rClrAddr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_in_range;
  logic              w_acc;
  logic              w_rd;
  logic              w_wr;
  logic              w_err;
  logic              w_clr_last;
  logic [DATA_W-1:0] w_rd_data;

  assign w_in_range = {1'b0, iAddrRam} < (ADDR_W+1)'(DEPTH);
  assign w_acc      = (r_state == ST_IDLE) && !iCsnRam;
  assign w_rd       = w_acc && iWrnRam;
  assign w_wr       = w_acc && !iWrnRam && w_in_range;
  assign w_err      = w_acc && !w_in_range;
  assign w_clr_last = (rClrAddr == ADDR_W'(DEPTH - 1));
  assign w_rd_data  = w_in_range ? r_mem[iAddrRam] : '0;
  assign oBusy      = (r_state == ST_CLEAR);

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = rClrAddr;
    case (r_state)
      ST_CLEAR: begin
        w_clr_addr_nxt = rClrAddr + ADDR_W'(1);
        if (w_clr_last) begin
          w_state_nxt    = ST_IDLE;
          w_clr_addr_nxt = '0;
        end
      end
      default: begin
        if (iClrReq) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      r_state  <= ST_CLEAR;
      rClrAddr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      rClrAddr <= w_clr_addr_nxt;
    end
  end

  // The clear engine owns the write port while busy; accesses are ignored then.
  always_ff @(posedge iClk12M) begin
    if (!iRst) begin
      if (r_state == ST_CLEAR)
        r_mem[rClrAddr] <= INIT_VAL;
      else if (w_wr)
        r_mem[iAddrRam] <= iWtDtRam;
    end
  end

  // Stage p0: array read / error detect
  logic [DATA_W-1:0] r_rd_dat_p0;
  logic              r_vld_p0;
  logic              r_err_p0;

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge iClk12M) begin
      if (iRst) begin
        r_rd_dat_p0 <= '0;
        r_vld_p0    <= 1'b0;
        r_err_p0    <= 1'b0;
      end else begin
        r_vld_p0 <= w_rd;
        r_err_p0 <= w_err;
        if (w_rd)
          r_rd_dat_p0 <= w_rd_data;
      end
    end

    assign oRdDtRam = r_rd_dat_p0;
    assign oRdValid = r_vld_p0;
    assign oAddrErr = r_err_p0;
  end else begin : g_lat2
    logic [DATA_W-1:0] r_rd_dat_p1;
    logic              r_vld_p1;
    logic              r_err_p1;

    always_ff @(posedge iClk12M) begin
      if (w_rd)
        r_rd_dat_p0 <= w_rd_data;
    end

    always_ff @(posedge iClk12M) begin
      if (iRst) begin
        r_vld_p0 <= 1'b0;
        r_err_p0 <= 1'b0;
      end else begin
        r_vld_p0 <= w_rd;
        r_err_p0 <= w_err;
      end
    end

    // Stage p1: output register; data holds unless a read completes
    always_ff @(posedge iClk12M) begin
      if (iRst) begin
        r_rd_dat_p1 <= '0;
        r_vld_p1    <= 1'b0;
        r_err_p1    <= 1'b0;
      end else begin
        r_vld_p1 <= r_vld_p0;
        r_err_p1 <= r_err_p0;
        if (r_vld_p0)
          r_rd_dat_p1 <= r_rd_dat_p0;
      end
    end

    assign oRdDtRam = r_rd_dat_p1;
    assign oRdValid = r_vld_p1;
    assign oAddrErr = r_err_p1;
  end

endmodule

// File: tb/tb_sp_sram_param.sv
// Scoreboard bench for sp_sram_param: a 10x16 RD_LAT=1 instance and a
// 64x32 RD_LAT=2 instance, each checked against an array-based reference.
module tb_sp_sram_param;

  localparam int DA = 10;
  localparam int LA = 1;
  localparam int DB = 64;
  localparam int LB = 2;

  typedef struct {
    int          due;
    bit          vld;
    bit          err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst = 1'b1, a_csn = 1'b1, a_wrn = 1'b1, a_clr = 1'b0;
  logic [3:0]  a_addr = '0;
  logic [15:0] a_wd = '0;
  logic [15:0] a_rd;
  logic        a_vld, a_err, a_busy;

  logic        b_rst = 1'b1, b_csn = 1'b1, b_wrn = 1'b1, b_clr = 1'b0;
  logic [5:0]  b_addr = '0;
  logic [31:0] b_wd = '0;
  logic [31:0] b_rd;
  logic        b_vld, b_err, b_busy;

  sp_sram_param #(.DATA_W(16), .DEPTH(DA), .ADDR_W(4), .RD_LAT(LA), .INIT_VAL(16'h0000)) u_dut_a (
    .iClk12M(clk), .iRst(a_rst), .iCsnRam(a_csn), .iWrnRam(a_wrn), .iAddrRam(a_addr),
    .iWtDtRam(a_wd), .iClrReq(a_clr), .oRdDtRam(a_rd), .oRdValid(a_vld),
    .oAddrErr(a_err), .oBusy(a_busy));

  sp_sram_param #(.DATA_W(32), .DEPTH(DB), .ADDR_W(6), .RD_LAT(LB), .INIT_VAL(32'h0)) u_dut_b (
    .iClk12M(clk), .iRst(b_rst), .iCsnRam(b_csn), .iWrnRam(b_wrn), .iAddrRam(b_addr),
    .iWtDtRam(b_wd), .iClrReq(b_clr), .oRdDtRam(b_rd), .oRdValid(b_vld),
    .oAddrErr(b_err), .oBusy(b_busy));

  // Reference state: word arrays, remaining clear cycles, expected outputs.
  logic [15:0] ma [DA];
  logic [31:0] mb [DB];
  int          busy_a = 0;
  int          busy_b = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  bit          eb_a [int];
  bit          eb_b [int];
  bit          rs_a [int];
  bit          rs_b [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step_a(input bit rst, input bit csn, input bit wrn, input int addr,
                        input logic [31:0] wd, input bit clr);
    int c;
    exp_t e;
    @(posedge clk);
    #1;
    a_rst = rst; a_csn = csn; a_wrn = wrn; a_addr = 4'(addr); a_wd = wd[15:0]; a_clr = clr;
    c = cyc;
    if (rst) begin
      busy_a = DA;
      foreach (ma[i]) ma[i] = '0;
      rs_a[c+1] = 1'b1;
    end else if (busy_a > 0) begin
      busy_a--;
    end else begin
      if (!csn) begin
        if (addr < DA) begin
          if (wrn) begin
            e = '{c + LA, 1'b1, 1'b0, 32'(ma[addr])};
            q_a.push_back(e);
          end else begin
            ma[addr] = wd[15:0];
          end
        end else begin
          e = '{c + LA, wrn, 1'b1, 32'h0};
          q_a.push_back(e);
        end
      end
      if (clr) begin
        busy_a = DA;
        foreach (ma[i]) ma[i] = '0;
      end
    end
    eb_a[c+1] = (busy_a > 0);
  endtask

  task automatic step_b(input bit rst, input bit csn, input bit wrn, input int addr,
                        input logic [31:0] wd, input bit clr);
    int c;
    exp_t e;
    @(posedge clk);
    #1;
    b_rst = rst; b_csn = csn; b_wrn = wrn; b_addr = 6'(addr); b_wd = wd; b_clr = clr;
    c = cyc;
    if (rst) begin
      busy_b = DB;
      foreach (mb[i]) mb[i] = '0;
      rs_b[c+1] = 1'b1;
    end else if (busy_b > 0) begin
      busy_b--;
    end else begin
      if (!csn) begin
        if (wrn) begin
          e = '{c + LB, 1'b1, 1'b0, mb[addr]};
          q_b.push_back(e);
        end else begin
          mb[addr] = wd;
        end
      end
      if (clr) begin
        busy_b = DB;
        foreach (mb[i]) mb[i] = '0;
      end
    end
    eb_b[c+1] = (busy_b > 0);
  endtask

  initial begin : mon_a
    int k;
    exp_t e;
    logic [31:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      k = cyc;
      if (eb_a.exists(k)) begin
        if (rs_a.exists(k)) last = '0;
        chk("a_busy", 32'(a_busy), 32'(eb_a[k]));
        if (q_a.size() > 0 && q_a[0].due == k) begin
          e = q_a.pop_front();
          chk("a_vld", 32'(a_vld), 32'(e.vld));
          chk("a_err", 32'(a_err), 32'(e.err));
          if (e.vld) last = e.data;
        end else begin
          chk("a_vld_idle", 32'(a_vld), 32'h0);
          chk("a_err_idle", 32'(a_err), 32'h0);
        end
        chk("a_rdata", 32'(a_rd), last);
      end
    end
  end

  initial begin : mon_b
    int k;
    exp_t e;
    logic [31:0] last;
    last = '0;
    forever begin
      @(negedge clk);
      k = cyc;
      if (eb_b.exists(k)) begin
        if (rs_b.exists(k)) last = '0;
        chk("b_busy", 32'(b_busy), 32'(eb_b[k]));
        if (q_b.size() > 0 && q_b[0].due == k) begin
          e = q_b.pop_front();
          chk("b_vld", 32'(b_vld), 32'(e.vld));
          chk("b_err", 32'(b_err), 32'(e.err));
          if (e.vld) last = e.data;
        end else begin
          chk("b_vld_idle", 32'(b_vld), 32'h0);
          chk("b_err_idle", 32'(b_err), 32'h0);
        end
        chk("b_rdata", b_rd, last);
      end
    end
  end

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step_a(0, 1, 1, 0, 0, 0);
  endtask

  task automatic read_all_a();
    for (int i = 0; i < DA; i++) step_a(0, 0, 1, i, 0, 0);
  endtask

  task automatic run_a();
    step_a(1, 1, 1, 0, 0, 0);
    step_a(1, 1, 1, 0, 0, 0);
    step_a(0, 0, 1, 2, 0, 0);
    idle_a(11);
    read_all_a();
    step_a(0, 0, 0, 3, 32'hA5A5, 0);
    step_a(0, 0, 1, 3, 0, 0);
    idle_a(2);
    step_a(0, 0, 1, 12, 0, 0);
    step_a(0, 0, 0, 10, 32'hFFFF, 0);
    step_a(0, 0, 0, 15, 32'hFFFF, 0);
    read_all_a();
    for (int i = 0; i < DA; i++) step_a(0, 0, 0, i, 32'h1000 + i, 0);
    step_a(0, 0, 1, 5, 0, 1);
    step_a(0, 0, 1, 2, 0, 0);
    step_a(0, 0, 0, 4, 32'h7777, 0);
    idle_a(9);
    read_all_a();
    for (int i = 0; i < DA; i++) step_a(0, 0, 0, i, 32'h2000 + i, 0);
    step_a(0, 1, 1, 0, 0, 1);
    idle_a(3);
    step_a(1, 1, 1, 0, 0, 0);
    idle_a(11);
    read_all_a();
    for (int i = 0; i < 300; i++)
      step_a($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1),
             $urandom_range(0, 15), $urandom, $urandom_range(0, 59) == 0);
    idle_a(12);
    read_all_a();
    idle_a(4);
  endtask

  task automatic run_b();
    step_b(1, 1, 1, 0, 0, 0);
    step_b(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < DB + 2; i++) step_b(0, 1, 1, 0, 0, 0);
    step_b(0, 0, 1, 3, 0, 0);
    step_b(0, 0, 0, 3, 32'hA5A5, 0);
    step_b(0, 0, 1, 3, 0, 0);
    for (int i = 0; i < DB; i++) step_b(0, 0, 0, i, $urandom, 0);
    for (int i = 0; i < DB; i++) step_b(0, 0, 1, i, 0, 0);
    for (int i = 0; i < 400; i++)
      step_b(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, DB - 1),
             $urandom, $urandom_range(0, 149) == 0);
    step_b(0, 0, 1, 7, 0, 1);
    for (int i = 0; i < DB + 1; i++) step_b(0, 0, 1, i % DB, 0, 0);
    for (int i = 0; i < 8; i++) step_b(0, 0, 1, i, 0, 0);
    for (int i = 0; i < 4; i++) step_b(0, 1, 1, 0, 0, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    fork
      run_a();
      run_b();
    join
    @(negedge clk);
    @(negedge clk);
    chk("a_pending", 32'(q_a.size()), 32'h0);
    chk("b_pending", 32'(q_b.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
